generic_output_ctrl: RTL and testbench

// Synthesisable, multi-channel successor to the single-bank output model, for

---
 rtl/generic_output_ctrl.sv | 120 ++++++++++++
 tb/tb_generic_output_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/generic_output_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : generic_output_ctrl
// Description : Multi-channel output controller with per-channel off/on/blink/
//               PWM modes, a shared prescaler and a change-pulse flag.
// Revision    : 1.0 - initial release
// ============================================================================
module generic_output_ctrl #(
    parameter int            OW    = 8,
    parameter int            AW    = 3,
    parameter int            PW    = 4,
    parameter logic [OW-1:0] DS    = '0,
    parameter int            PRESC = 1000,
    parameter int            BLINK = 250
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [PW+1:0] dat_w,
    output logic [PW+1:0] dat_r,
    output logic [OW-1:0] o,
    output logic          chg
);

    localparam int c_PCW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int c_BCW = (BLINK > 1) ? $clog2(BLINK) : 1;
    localparam logic [c_PCW-1:0] c_PRESC_LAST = c_PCW'(PRESC - 1);
    localparam logic [c_BCW-1:0] c_BLINK_LAST = c_BCW'(BLINK - 1);

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;

    logic [PW+1:0]    r_reg [OW];
    logic [c_PCW-1:0] r_presc;
    logic [PW-1:0]    r_pwm;
    logic [c_BCW-1:0] r_blink;
    logic             r_phase;
    logic [OW-1:0]    r_o;
    logic             r_chg;

    logic             w_tick;
    logic             w_blink_wrap;
    logic [OW-1:0]    w_act;
    logic [OW-1:0]    w_o_next;

    assign w_tick       = (r_presc == c_PRESC_LAST);
    assign w_blink_wrap = w_tick && (r_blink == c_BLINK_LAST);
    assign w_o_next     = DS ^ w_act;

    // Shared timebase; channel writes never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PCW'(1);
            if (w_tick) begin
                r_pwm <= r_pwm + PW'(1);
            end
            if (w_blink_wrap) begin
                r_blink <= '0;
                r_phase <= ~r_phase;
            end else if (w_tick) begin
                r_blink <= r_blink + c_BCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o   <= DS;
            r_chg <= 1'b0;
        end else begin
            r_o   <= w_o_next;
            r_chg <= (w_o_next != r_o);
        end
    end

    generate
        for (genvar n = 0; n < OW; n++) begin : g_chan
            logic [1:0]    w_mode;
            logic [PW-1:0] w_duty;

            assign w_mode = r_reg[n][PW+1:PW];
            assign w_duty = r_reg[n][PW-1:0];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reg[n] <= '0;
                end else if (we && (adr == AW'(n))) begin
                    r_reg[n] <= dat_w;
                end
            end

            // Duty 0 can never satisfy the compare, so it is always off.
            assign w_act[n] = (w_mode == c_MODE_OFF)   ? 1'b0 :
                              (w_mode == c_MODE_ON)    ? 1'b1 :
                              (w_mode == c_MODE_BLINK) ? r_phase :
                                                         (r_pwm < w_duty);
        end
    endgenerate

    always_comb begin
        dat_r = '0;
        for (int n = 0; n < OW; n++) begin
            if (adr == AW'(n)) begin
                dat_r = r_reg[n];
            end
        end
    end

    assign o   = r_o;
    assign chg = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_generic_output_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_generic_output_ctrl
// Description : Three differently parameterised controllers share one stimulus
//               stream and are compared against a tick-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_output_ctrl;

    localparam int             NC         = 3;
    localparam int             PRESC_T[NC] = '{2, 1, 1};
    localparam int             BLINK_T[NC] = '{3, 3, 2};
    localparam logic [7:0]     DS_T[NC]    = '{8'h00, 8'h00, 8'hFF};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [3:0] adr = '0;
    logic [5:0] dat_w = '0;
    logic [5:0] dat_r_v [NC];
    logic [7:0] o_v     [NC];
    logic       chg_v   [NC];

    always #5 clk = ~clk;

    generic_output_ctrl #(.OW(8), .AW(4), .PW(4), .DS(8'h00), .PRESC(2), .BLINK(3)) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .adr(adr), .dat_w(dat_w),
        .dat_r(dat_r_v[0]), .o(o_v[0]), .chg(chg_v[0]));
    generic_output_ctrl #(.OW(8), .AW(4), .PW(4), .DS(8'h00), .PRESC(1), .BLINK(3)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .adr(adr), .dat_w(dat_w),
        .dat_r(dat_r_v[1]), .o(o_v[1]), .chg(chg_v[1]));
    generic_output_ctrl #(.OW(8), .AW(4), .PW(4), .DS(8'hFF), .PRESC(1), .BLINK(2)) u_dut_c (
        .clk(clk), .rst(rst), .we(we), .adr(adr), .dat_w(dat_w),
        .dat_r(dat_r_v[2]), .o(o_v[2]), .chg(chg_v[2]));

    int         n_vec = 0;
    int         n_err = 0;
    int         t = 0;          // non-reset edges since the last reset
    bit         model_ok = 1'b0;
    logic [5:0] m_reg [8];
    logic [7:0] m_o   [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counters are pure functions of elapsed cycles since reset.
    function automatic logic [7:0] exp_o(input int k);
        int         ticks;
        int         pwm;
        logic       ph;
        logic [7:0] act;
        ticks = t / PRESC_T[k];
        pwm   = ticks % 16;
        ph    = ((ticks / BLINK_T[k]) % 2) == 1;
        for (int n = 0; n < 8; n++) begin
            case (m_reg[n][5:4])
                2'd0:    act[n] = 1'b0;
                2'd1:    act[n] = 1'b1;
                2'd2:    act[n] = ph;
                default: act[n] = (pwm < int'(m_reg[n][3:0]));
            endcase
        end
        return DS_T[k] ^ act;
    endfunction

    task automatic cycle();
        logic [7:0] nxt [NC];
        #1;
        if (model_ok) begin
            for (int k = 0; k < NC; k++) begin
                chk($sformatf("dat_r%0d adr=%0d", k, adr), dat_r_v[k],
                    (adr < 4'd8) ? m_reg[adr[2:0]] : 6'd0);
            end
        end
        for (int k = 0; k < NC; k++) nxt[k] = exp_o(k);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int n = 0; n < 8; n++) m_reg[n] = '0;
            t = 0;
            model_ok = 1'b1;
            for (int k = 0; k < NC; k++) begin
                chk($sformatf("rst_o%0d", k), o_v[k], DS_T[k]);
                chk($sformatf("rst_chg%0d", k), chg_v[k], 0);
                m_o[k] = DS_T[k];
            end
        end else begin
            for (int k = 0; k < NC; k++) begin
                chk($sformatf("o%0d t=%0d", k, t), o_v[k], nxt[k]);
                chk($sformatf("chg%0d t=%0d", k, t), chg_v[k], (nxt[k] != m_o[k]));
                m_o[k] = nxt[k];
            end
            if (we && adr < 4'd8) m_reg[adr[2:0]] = dat_w;
            t++;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        we = 1'b1; adr = a; dat_w = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic count_high(input int k, input int bitn, input int exp, input string tag);
        int cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (o_v[k][bitn]) cnt++;
        end
        chk(tag, cnt, exp);
    endtask

    initial begin
        int last_tog;
        logic prev;

        // Reset held with writes active, sweeping every address
        rst = 1'b1; we = 1'b1;
        for (int a = 0; a < 16; a++) begin
            adr = 4'(a); dat_w = 6'($urandom);
            cycle();
        end
        we = 1'b0; rst = 1'b0; adr = '0;

        // On mode: visible one edge after the write, chg for one cycle
        wr(4'd2, 6'b01_0000);
        cycle();
        chk("on_o2", o_v[0][2], 1);
        chk("on_chg", chg_v[0], 1);
        cycle();
        chk("on_chg_clear", chg_v[0], 0);
        wr(4'd8, 6'b01_0000);
        adr = 4'd8;
        idle(2);
        chk("oob_o", o_v[0], 8'h04);

        // Blink on two channels: toggles every 6 clk, in step
        wr(4'd0, 6'b10_0000);
        wr(4'd4, 6'b10_0000);
        cycle();
        prev = o_v[0][0];
        last_tog = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("blink_inphase", o_v[0][4], o_v[0][0]);
            if (o_v[0][0] !== prev) begin
                if (last_tog >= 0) chk("blink_period", i - last_tog, 6);
                last_tog = i;
                prev = o_v[0][0];
            end
        end

        // PWM on the PRESC=1 instance
        wr(4'd1, 6'b11_0000);
        cycle();
        count_high(1, 1, 0, "pwm_duty0");
        wr(4'd1, 6'b11_0100);
        cycle();
        count_high(1, 1, 4, "pwm_duty4");
        wr(4'd1, 6'b11_1111);
        cycle();
        count_high(1, 1, 15, "pwm_duty15");

        // Inverted default level, then reset mid-PWM
        wr(4'd3, 6'b01_0000);
        cycle();
        chk("ds_inv_o3", o_v[2][3], 0);
        idle(5);
        rst = 1'b1;
        cycle();
        chk("midrst_o", o_v[2], 8'hFF);
        chk("midrst_chg", chg_v[2], 0);
        rst = 1'b0;

        // Random traffic including out-of-range addresses and rare resets
        for (int i = 0; i < 10000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            we    = $urandom_range(0, 1) == 1;
            adr   = 4'($urandom);
            dat_w = 6'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
